// File: rtl/decode_queue.sv
// decode_queue
//   Buffered RV32I(+M) instruction-decode stage. Raw instructions arriving
//   from fetch are decoded combinationally into a control bundle (ALU op,
//   immediate, register fields, control flags, illegal marker) and the
//   bundle is stored with its PC in a DEPTH-entry FIFO that decouples fetch
//   stalls from issue stalls. A flush empties the queue and drops any
//   same-cycle input.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset (acts as a flush)
//   flush                 discard all queued entries and the same-cycle input
//   in_valid/in_ready     upstream handshake; in_ready = (count < DEPTH)
//   in_inst, in_pc        raw instruction and its PC
//   out_valid/out_ready   downstream handshake; pop when both are high
//   out_*                 decoded bundle of the head entry (all zero when empty)
//   count                 current occupancy, 0..DEPTH
module decode_queue #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter bit ENABLE_M   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INST_WIDTH-1:0]   in_inst,
    input  logic [ADDR_WIDTH-1:0]   in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [2:0]              out_funct3,
    output logic [4:0]              out_alu_op,
    output logic [2:0]              out_imm_type,
    output logic [31:0]             out_imm,
    output logic                    out_alu_src,
    output logic                    out_reg_write,
    output logic                    out_mem_read,
    output logic                    out_mem_write,
    output logic                    out_branch,
    output logic                    out_jump,
    output logic                    out_jalr,
    output logic                    out_lui,
    output logic                    out_auipc,
    output logic                    out_system,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000, ALU_SUB   = 5'b00001, ALU_SLL    = 5'b00010,
        ALU_SLT    = 5'b00011, ALU_SLTU  = 5'b00100, ALU_XOR    = 5'b00101,
        ALU_SRL    = 5'b00110, ALU_SRA   = 5'b00111, ALU_OR     = 5'b01000,
        ALU_AND    = 5'b01001, ALU_LUI   = 5'b01010, ALU_AUIPC  = 5'b01011,
        ALU_EQ     = 5'b01100, ALU_NE    = 5'b01101, ALU_LT     = 5'b01110,
        ALU_GE     = 5'b01111, ALU_LTU   = 5'b10000, ALU_GEU    = 5'b10001,
        ALU_MUL    = 5'b10010, ALU_MULH  = 5'b10011, ALU_MULHSU = 5'b10100,
        ALU_MULHU  = 5'b10101, ALU_DIV   = 5'b10110, ALU_DIVU   = 5'b10111,
        ALU_REM    = 5'b11000, ALU_REMU  = 5'b11001
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100
    } imm_type_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [2:0]            funct3;
        alu_op_e               alu_op;
        imm_type_e             imm_type;
        logic [31:0]           imm;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  jalr;
        logic                  lui;
        logic                  auipc;
        logic                  system;
        logic                  illegal;
    } entry_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Integer ALU op for OP / OP-IMM; alt selects SUB/SRA.
    function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e m_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        illegal;
    entry_t      dec;
    entry_t      entry_new;

    assign inst   = in_inst[31:0];
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        dec        = '0;
        dec.pc     = in_pc;
        dec.rd     = inst[11:7];
        dec.rs1    = inst[19:15];
        dec.rs2    = inst[24:20];
        dec.funct3 = funct3;
        illegal    = 1'b0;

        case (opcode)
            OPC_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.lui       = 1'b1;
                dec.alu_op    = ALU_LUI;
                dec.imm_type  = IMM_U;
                dec.imm       = imm_u;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.auipc     = 1'b1;
                dec.alu_op    = ALU_AUIPC;
                dec.imm_type  = IMM_U;
                dec.imm       = imm_u;
            end
            OPC_JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.imm_type  = IMM_J;
                dec.imm       = imm_j;
            end
            OPC_JALR: begin
                dec.reg_write = 1'b1;
                dec.jalr      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                illegal       = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.branch   = 1'b1;
                dec.imm_type = IMM_B;
                dec.imm      = imm_b;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_EQ;
                    3'b001:  dec.alu_op = ALU_NE;
                    3'b100:  dec.alu_op = ALU_LT;
                    3'b101:  dec.alu_op = ALU_GE;
                    3'b110:  dec.alu_op = ALU_LTU;
                    3'b111:  dec.alu_op = ALU_GEU;
                    default: illegal    = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                illegal       = funct3 inside {3'b011, 3'b110, 3'b111};
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_type  = IMM_S;
                dec.imm       = imm_s;
                illegal       = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                // funct7 only qualifies the shift-immediate forms.
                dec.alu_op    = base_alu(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec.alu_op = base_alu(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec.alu_op = base_alu(funct3, 1'b1);
                end else if (funct7 == F7_MEXT && ENABLE_M) begin
                    dec.alu_op = m_alu(funct3);
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE: legal no-op, no control flags.
            end
            OPC_SYSTEM: begin
                dec.system    = 1'b1;
                dec.reg_write = (funct3 != 3'b000);
                dec.imm       = imm_i;
            end
            default: illegal = 1'b1;
        endcase

        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end

        // Illegal entries keep PC and raw fields for the trap handler; all
        // control is cleared so nothing downstream acts on them.
        if (illegal) begin
            entry_new         = '0;
            entry_new.pc      = dec.pc;
            entry_new.rd      = dec.rd;
            entry_new.rs1     = dec.rs1;
            entry_new.rs2     = dec.rs2;
            entry_new.funct3  = dec.funct3;
            entry_new.illegal = 1'b1;
        end else begin
            entry_new = dec;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    entry_t             head;

    // in_ready ignores out_ready: a full queue never accepts, even on a pop.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = entry_new;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // observable once count covers it, and outputs are gated while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign out_pc        = head.pc;
    assign out_rd        = head.rd;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_funct3    = head.funct3;
    assign out_alu_op    = head.alu_op;
    assign out_imm_type  = head.imm_type;
    assign out_imm       = head.imm;
    assign out_alu_src   = head.alu_src;
    assign out_reg_write = head.reg_write;
    assign out_mem_read  = head.mem_read;
    assign out_mem_write = head.mem_write;
    assign out_branch    = head.branch;
    assign out_jump      = head.jump;
    assign out_jalr      = head.jalr;
    assign out_lui       = head.lui;
    assign out_auipc     = head.auipc;
    assign out_system    = head.system;
    assign out_illegal   = head.illegal;
    assign count         = count_q;

endmodule
